// File: rtl/sent_apb_pkg.sv
// Shared constants for the SENT APB initiator: bus widths, FSM encoding and
// SENT register map addresses.
package sent_apb_pkg;

    localparam int unsigned SENT_APB_ADDR_W    = 3;
    localparam int unsigned SENT_APB_DATA_W    = 12;
    localparam int unsigned SENT_APB_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // SENT slave register map
    localparam logic [SENT_APB_ADDR_W-1:0] SENT_REG_CTRL   = 3'd2;
    localparam logic [SENT_APB_ADDR_W-1:0] SENT_REG_TXDATA = 3'd4;

endpackage

// File: rtl/sent_apb_master.sv
// Single-outstanding APB initiator for the SENT block's register port.
// Optional ACCESS-phase timeout enabled by defining SENT_APB_TIMEOUT_EN.
module sent_apb_master
    import sent_apb_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH   = SENT_APB_ADDR_W,
    parameter int unsigned DATAWIDTH      = SENT_APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATAWIDTH-1:0]    rsp_rdata,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic [DATAWIDTH-1:0]    PRDATA,
    input  logic                    PREADY
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("sent_apb_master: TIMEOUT_CYCLES must be in 1..255");
    end

    apb_state_e              state_q, state_d;
    logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
    logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    busy_q, busy_d;

`ifdef SENT_APB_TIMEOUT_EN
    localparam logic [SENT_APB_TIMEOUT_W-1:0] TMO_TERM = SENT_APB_TIMEOUT_W'(TIMEOUT_CYCLES);
    logic [SENT_APB_TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SENT_APB_TIMEOUT_W-1:0] tmo_cnt_inc;
    assign tmo_cnt_inc = tmo_cnt_q + SENT_APB_TIMEOUT_W'(1);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef SENT_APB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef SENT_APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                // PREADY on the terminal-count edge still completes normally
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end
`ifdef SENT_APB_TIMEOUT_EN
                else if (tmo_cnt_inc == TMO_TERM) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

`ifdef SENT_APB_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_sent_apb_master.sv
// Directed bench for sent_apb_master; timeout scenario built when
// SENT_APB_TIMEOUT_EN is defined, wait-forever scenario otherwise.
module tb_sent_apb_master;
    import sent_apb_pkg::*;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [11:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  PADDR;
    logic [11:0] PWDATA;
    logic        PWRITE;
    logic        PSELx;
    logic        PENABLE;
    logic [11:0] PRDATA;
    logic        PREADY;

    int errors = 0;
    int checks = 0;

    // {cmd_ready, busy, PSELx, PENABLE, rsp_valid, rsp_timeout}
    logic [5:0] st;
    assign st = {cmd_ready, busy, PSELx, PENABLE, rsp_valid, rsp_timeout};

    sent_apb_master #(
        .ADDRESSWIDTH  (3),
        .DATAWIDTH     (12),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0;
        tick(); tick();
        checks++;
        if (st !== 6'b100000) begin
            errors++; $display("FAIL reset_status got=%b exp=100000", st);
        end
        checks++;
        if ({PADDR, PWDATA, PWRITE, rsp_rdata} !== 28'd0) begin
            errors++; $display("FAIL reset_bus got=%h/%h/%b/%h exp=0", PADDR, PWDATA, PWRITE, rsp_rdata);
        end
        #2 PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int psel_cycles = 0;
        int pen_cycles  = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = SENT_REG_CTRL;
        cmd_wdata = 12'h0F4; PREADY = 1'b1; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (st !== 6'b011000) begin
            errors++; $display("FAIL wr_accept got=%b exp=011000", st);
        end
        checks++;
        if ({PADDR, PWDATA, PWRITE} !== {3'd2, 12'h0F4, 1'b1}) begin
            errors++; $display("FAIL wr_bus got=%h/%h/%b exp=2/0f4/1", PADDR, PWDATA, PWRITE);
        end
        psel_cycles += int'(PSELx); pen_cycles += int'(PENABLE);
        tick();
        checks++;
        if (st !== 6'b011100) begin
            errors++; $display("FAIL wr_access got=%b exp=011100", st);
        end
        psel_cycles += int'(PSELx); pen_cycles += int'(PENABLE);
        tick();
        checks++;
        if (st !== 6'b010010 || rsp_rdata !== 12'h000) begin
            errors++; $display("FAIL wr_rsp got=%b/%h exp=010010/000", st, rsp_rdata);
        end
        tick();
        checks++;
        if (st !== 6'b100000) begin
            errors++; $display("FAIL wr_done got=%b exp=100000", st);
        end
        checks++;
        if ({PADDR, PWDATA, PWRITE} !== {3'd2, 12'h0F4, 1'b1}) begin
            errors++; $display("FAIL wr_hold got=%h/%h/%b exp=2/0f4/1", PADDR, PWDATA, PWRITE);
        end
        checks++;
        if (psel_cycles != 2 || pen_cycles != 1) begin
            errors++; $display("FAIL wr_phase_count got=%0d/%0d exp=2/1", psel_cycles, pen_cycles);
        end
    endtask

    task automatic test_read_wait();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = SENT_REG_TXDATA;
        cmd_wdata = 12'h3C3; PREADY = 1'b0; PRDATA = 12'h111; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st !== 6'b011100 || PADDR !== 3'd4 || PWRITE !== 1'b0) begin
                errors++; $display("FAIL rd_wait%0d got=%b/%h/%b exp=011100/4/0", i, st, PADDR, PWRITE);
            end
        end
        PREADY = 1'b1; PRDATA = 12'hABC;
        tick();
        PRDATA = 12'h000;
        checks++;
        if (st !== 6'b010010 || rsp_rdata !== 12'hABC) begin
            errors++; $display("FAIL rd_rsp got=%b/%h exp=010010/abc", st, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_rsp_backpressure();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = SENT_REG_CTRL;
        PREADY = 1'b1; PRDATA = 12'h7E5; rsp_ready = 1'b0;
        tick();
        cmd_write = 1'b1; cmd_addr = SENT_REG_TXDATA; cmd_wdata = 12'h456;
        tick(); tick();
        PRDATA = 12'h000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st !== 6'b010010 || rsp_rdata !== 12'h7E5 || PADDR !== 3'd2) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=010010/7e5/2", i, st, rsp_rdata, PADDR);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (st !== 6'b100000) begin
            errors++; $display("FAIL bp_release got=%b exp=100000", st);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (st !== 6'b011000 || {PADDR, PWDATA, PWRITE} !== {3'd4, 12'h456, 1'b1}) begin
            errors++; $display("FAIL bp_next got=%b/%h/%h/%b exp=011000/4/456/1", st, PADDR, PWDATA, PWRITE);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int idx  = 0;
        int last = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = SENT_REG_TXDATA;
        cmd_wdata = 12'h001; PREADY = 1'b1; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 250 && idx < 42; cyc++) begin
            tick();
            if (PSELx && !PENABLE) begin
                checks++;
                if (PWDATA !== 12'(idx + 1)) begin
                    errors++; $display("FAIL b2b_data%0d got=%h exp=%h", idx, PWDATA, 12'(idx + 1));
                end
                if (idx > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++; $display("FAIL b2b_spacing%0d got=%0d exp=4", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
                if (idx == 42) cmd_valid = 1'b0;
                else cmd_wdata = 12'(idx + 1);
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (idx != 42) begin
            errors++; $display("FAIL b2b_count got=%0d exp=42", idx);
        end
        tick(); tick(); tick();
        checks++;
        if (st !== 6'b100000 || PWDATA !== 12'h02A) begin
            errors++; $display("FAIL b2b_end got=%b/%h exp=100000/02a", st, PWDATA);
        end
    endtask

`ifdef SENT_APB_TIMEOUT_EN
    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = SENT_REG_CTRL;
        PREADY = 1'b0; PRDATA = 12'hFFF; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (st !== 6'b011100) begin
                errors++; $display("FAIL tmo_wait%0d got=%b exp=011100", i, st);
            end
        end
        tick();
        checks++;
        if (st !== 6'b010011 || rsp_rdata !== 12'h000) begin
            errors++; $display("FAIL tmo_abort got=%b/%h exp=010011/000", st, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; PREADY = 1'b1; PRDATA = 12'h5A5;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        checks++;
        if (st !== 6'b010010 || rsp_rdata !== 12'h5A5) begin
            errors++; $display("FAIL tmo_recover got=%b/%h exp=010010/5a5", st, rsp_rdata);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = SENT_REG_CTRL;
        PREADY = 1'b0; PRDATA = 12'hFFF; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        repeat (40) tick();
        checks++;
        if (st !== 6'b011100) begin
            errors++; $display("FAIL wait_forever got=%b exp=011100", st);
        end
        PREADY = 1'b1; PRDATA = 12'h5A5;
        tick();
        checks++;
        if (st !== 6'b010010 || rsp_rdata !== 12'h5A5) begin
            errors++; $display("FAIL wait_complete got=%b/%h exp=010010/5a5", st, rsp_rdata);
        end
        tick();
    endtask
`endif

    task automatic test_reset_midflight();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = SENT_REG_TXDATA;
        cmd_wdata = 12'h9D1; PREADY = 1'b0; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        checks++;
        if (st !== 6'b011100) begin
            errors++; $display("FAIL rst_pre got=%b exp=011100", st);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if (st !== 6'b100000 || {PADDR, PWDATA, PWRITE, rsp_rdata} !== 28'd0) begin
            errors++; $display("FAIL rst_async got=%b/%h/%h/%b exp=100000/0/0/0", st, PADDR, PWDATA, PWRITE);
        end
        PREADY = 1'b1;
        #2 PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (st !== 6'b100000) begin
                errors++; $display("FAIL rst_after%0d got=%b exp=100000", i, st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_rsp_backpressure();
        test_back_to_back();
`ifdef SENT_APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
